dma_multi_channel: RTL and testbench
====================================

Name: dma_multi_channel

Overview:
- Parametrised successor to the single-channel ROM->RAM copy engine.
- NUM_CH independent channels each queue a block-copy request. The channels share one ROM read port and one RAM write port.
- A round-robin arbiter serves one channel's whole block at a time. Transfers are pipelined at 1 word/clock over a ROM with ROM_LATENCY read cycles.
- Sits between the control/sequencer logic and the on-chip ROM/RAM pair.

Parameters:
DATA_WIDTH, 8, data word width
ADDR_WIDTH, 4, ROM/RAM address width and transfer-count width
NUM_CH, 2, number of channels (1..8)
ROM_LATENCY, 1, clocks from rom_addr driven to rom_data valid (1..4)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start_dma  in  NUM_CH  per-channel request strobe, sampled each clock
data_amt  in  NUM_CH*ADDR_WIDTH  per-channel word count, channel i in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
starting_rom  in  NUM_CH*ADDR_WIDTH  per-channel source base, same packing
starting_ram  in  NUM_CH*ADDR_WIDTH  per-channel destination base, same packing
rom_data  in  DATA_WIDTH  ROM read data
rom_addr  out  ADDR_WIDTH  ROM read address
ram_addr  out  ADDR_WIDTH  RAM write address
ram_data  out  DATA_WIDTH  RAM write data
ram_wea  out  1  RAM write enable
busy  out  NUM_CH  channel has an accepted request not yet completed
done  out  NUM_CH  one-clock pulse when the channel's transfer completes

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0. Channel queues cleared, pipeline valid bits cleared, FSM to IDLE.
  - Round-robin pointer set to NUM_CH-1, so channel 0 has first priority.
  - Reset mid-transfer aborts the transfer immediately: no further writes and no done pulse.
- Request capture:
  - A start_dma[i]=1 at a rising edge with busy[i]=0 latches data_amt/starting_rom/starting_ram slice i. busy[i] is 1 from the next clock.
  - start_dma[i] while busy[i]=1 is ignored; no queueing depth beyond 1.
  - Inputs may change after capture.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - If any channel is pending (busy and not active), grant the first pending channel after the pointer, cyclically.
  - Update the pointer to the granted channel. Load src, dst and remaining count.
  - Go to ISSUE, or to FINISH if count=0.
  - Grant costs one clock.
- ISSUE:
  - Each clock drives rom_addr=src, pushes a valid bit into a ROM_LATENCY-deep shift pipeline, then src++ and remaining--.
  - When remaining reaches 0 after an issue, go to DRAIN.
- Write side:
  - When a valid bit exits the pipeline, in that clock ram_wea=1, ram_data=rom_data, ram_addr=dst, then dst++.
  - Word k is read in clock G+1+k and written in clock G+1+ROM_LATENCY+k, where G is the grant clock.
- DRAIN: wait until the pipeline is empty (last write done), then go to FINISH.
- FINISH:
  - For one clock: done[g]=1 and busy[g]=0 in the same clock; the active channel is released.
  - Then IDLE.
  - Latency for N words: done at clock G+N+ROM_LATENCY+1. For N=0: done at G+1, no writes, rom_addr holds last value.
- A start_dma[g] in the FINISH clock is not accepted (busy still 1 at that edge). It is accepted from the following clock.
- Address arithmetic is modulo 2^ADDR_WIDTH: src/dst wrap from all-ones to 0 with no error. Max transfer is 2^ADDR_WIDTH-1 words.
- Simultaneous requests are all captured in the same clock. They are served in round-robin order with no interleaving of blocks.
- ram_wea=0 whenever no pipeline valid bit exits. ram_addr/ram_data hold their last values when ram_wea=0.
- Back-to-back channels: at least one idle clock (IDLE grant) between blocks. No ROM/RAM port conflicts possible.

Test Plan:
- Single block: NUM_CH=2, ROM_LATENCY=1, ch0 amt=4, rom=2, ram=8, ROM[a]=a+0x10 -> ram_wea high for exactly 4 clocks, writing RAM[8..11]=0x12..0x15. done[0] pulses once, 6 clocks after grant. busy[0] is 0 afterwards.
- Arbitration: start_dma=2'b11 same clock, ch0 amt=3, ch1 amt=2 -> ch0 block completes fully, then ch1. The next simultaneous pair is served ch0 then ch1 again, because the pointer rotates. No write interleaving.
- Wrap and latency: ROM_LATENCY=3, amt=4, rom=14, ram=15 -> reads 14,15,0,1. Writes go to RAM 15,0,1,2 with correct data. First write is 3 clocks after the first read.
- Zero length plus ignored restart: amt=0 -> done pulse at grant+1, ram_wea never asserted. A start_dma re-asserted while busy with a different amt is ignored, and the original amt is used.
- Reset mid-transfer: assert reset at the 2nd write of an 8-word block -> from the next clock ram_wea=0, busy=0, done=0. A new request after reset runs normally from channel 0.
- Re-trigger timing: start_dma[0] held high continuously with amt=1 -> repeated transfers, each accepted the clock after done[0], never in the done clock.

Source files
------------

// File: rtl/dma_multi_channel.sv
// Multi-channel ROM->RAM block-copy engine: NUM_CH request slots share one ROM read
// port and one RAM write port, served whole-block at a time in round-robin order.
module dma_multi_channel #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int NUM_CH      = 2,
   parameter int ROM_LATENCY = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            start_dma,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] data_amt,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] starting_rom,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] starting_ram,
   input  logic [DATA_WIDTH-1:0]        rom_data,
   output logic [ADDR_WIDTH-1:0]        rom_addr,
   output logic [ADDR_WIDTH-1:0]        ram_addr,
   output logic [DATA_WIDTH-1:0]        ram_data,
   output logic                         ram_wea,
   output logic [NUM_CH-1:0]            busy,
   output logic [NUM_CH-1:0]            done
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [ROM_LATENCY-1:0] TAIL = ROM_LATENCY'(1) << (ROM_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

   state_t                 state, state_nxt;
   logic [NUM_CH-1:0]      busy_q;
   logic [ADDR_WIDTH-1:0]  amt_q [NUM_CH];
   logic [ADDR_WIDTH-1:0]  rom_q [NUM_CH];
   logic [ADDR_WIDTH-1:0]  ram_q [NUM_CH];
   logic [CH_W-1:0]        ptr, gnt, pick;
   logic [ADDR_WIDTH-1:0]  src, dst, rem;
   logic [ROM_LATENCY-1:0] vpipe;
   logic [ADDR_WIDTH-1:0]  rom_addr_q, ram_addr_q;
   logic [DATA_WIDTH-1:0]  ram_data_q;
   logic                   issue;

   // Scan downwards so the nearest pending channel after ptr is the last one written.
   always_comb begin
      pick = ptr;
      for (int i = NUM_CH; i >= 1; i--) begin
         int idx;
         idx = (int'(ptr) + i) % NUM_CH;
         if (busy_q[idx]) pick = CH_W'(idx);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees
      // the pre-edge values of the others, independent of statement order.
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves state_nxt unassigned,
      // which would otherwise infer a latch.
      state_nxt = state;
      case (state)
         IDLE:    if (|busy_q) state_nxt = (amt_q[pick] == '0) ? FINISH : ISSUE;
         ISSUE:   if (rem == ADDR_WIDTH'(1)) state_nxt = DRAIN;
         DRAIN:   if ((vpipe & ~TAIL) == '0) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      issue    = (state == ISSUE);
      rom_addr = issue ? src : rom_addr_q;
      busy     = busy_q;
      done     = '0;
      if (state == FINISH) begin
         busy[gnt] = 1'b0;
         done[gnt] = 1'b1;
      end
   end

   // Write side is combinational off the pipeline tail so rom_data lands in the same clock.
   assign ram_wea  = vpipe[ROM_LATENCY-1];
   assign ram_addr = ram_wea ? dst : ram_addr_q;
   assign ram_data = ram_wea ? rom_data : ram_data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q     <= '0;
         ptr        <= CH_W'(NUM_CH - 1);
         gnt        <= '0;
         src        <= '0;
         dst        <= '0;
         rem        <= '0;
         vpipe      <= '0;
         rom_addr_q <= '0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            amt_q[i] <= '0;
            rom_q[i] <= '0;
            ram_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (start_dma[i] && !busy_q[i]) begin
               busy_q[i] <= 1'b1;
               amt_q[i]  <= data_amt[i*ADDR_WIDTH +: ADDR_WIDTH];
               rom_q[i]  <= starting_rom[i*ADDR_WIDTH +: ADDR_WIDTH];
               ram_q[i]  <= starting_ram[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
         end
         if (state == FINISH) busy_q[gnt] <= 1'b0;

         if (state == IDLE && |busy_q) begin
            gnt <= pick;
            ptr <= pick;
            src <= rom_q[pick];
            dst <= ram_q[pick];
            rem <= amt_q[pick];
         end

         if (issue) begin
            rom_addr_q <= src;
            src        <= src + 1'b1;
            rem        <= rem - 1'b1;
         end

         vpipe[0] <= issue;
         for (int i = 1; i < ROM_LATENCY; i++) vpipe[i] <= vpipe[i-1];

         if (ram_wea) begin
            ram_addr_q <= dst;
            ram_data_q <= rom_data;
            dst        <= dst + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dma_multi_channel.sv
// Directed bench: one DUT with ROM_LATENCY=1 and one with ROM_LATENCY=3, each fed by a
// behavioural ROM holding ROM[a] = 0x10 + a.
module tb_dma_multi_channel;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] start_dma, start3;
   logic [7:0] data_amt, starting_rom, starting_ram;
   logic [7:0] rom_data, rom_data3;
   logic [3:0] rom_addr, ram_addr, rom_addr3, ram_addr3;
   logic [7:0] ram_data, ram_data3;
   logic       ram_wea, ram_wea3;
   logic [1:0] busy, done, busy3, done3;
   logic [3:0] a1, a2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dma_multi_channel #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_CH(2), .ROM_LATENCY(1)) dut (
      .clk(clk), .reset(reset), .start_dma(start_dma), .data_amt(data_amt),
      .starting_rom(starting_rom), .starting_ram(starting_ram), .rom_data(rom_data),
      .rom_addr(rom_addr), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wea(ram_wea),
      .busy(busy), .done(done));

   dma_multi_channel #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_CH(2), .ROM_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .start_dma(start3), .data_amt(data_amt),
      .starting_rom(starting_rom), .starting_ram(starting_ram), .rom_data(rom_data3),
      .rom_addr(rom_addr3), .ram_addr(ram_addr3), .ram_data(ram_data3), .ram_wea(ram_wea3),
      .busy(busy3), .done(done3));

   always @(posedge clk) begin
      rom_data  <= {4'h1, rom_addr};
      a1        <= rom_addr3;
      a2        <= a1;
      rom_data3 <= {4'h1, a2};
   end

   // Observation mux so one block checker serves both instances.
   logic       use3 = 1'b0;
   logic [3:0] o_rom_addr, o_ram_addr;
   logic [7:0] o_ram_data;
   logic       o_wea;
   logic [1:0] o_busy, o_done;
   assign o_rom_addr = use3 ? rom_addr3 : rom_addr;
   assign o_ram_addr = use3 ? ram_addr3 : ram_addr;
   assign o_ram_data = use3 ? ram_data3 : ram_data;
   assign o_wea      = use3 ? ram_wea3  : ram_wea;
   assign o_busy     = use3 ? busy3     : busy;
   assign o_done     = use3 ? done3     : done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int ch, input int amt, input int rs, input int ws);
      data_amt[ch*4 +: 4]     = 4'(amt);
      starting_rom[ch*4 +: 4] = 4'(rs);
      starting_ram[ch*4 +: 4] = 4'(ws);
   endtask

   // Called at the negedge of the grant clock G; returns at the negedge of the done clock.
   task automatic expect_block(input int ch, input int n, input int rs, input int ws, input int lat);
      int done_c;
      done_c = (n == 0) ? 1 : n + lat + 1;
      for (int c = 1; c <= done_c; c++) begin
         @(negedge clk);
         if (c <= n) check($sformatf("ch%0d rom_addr c%0d", ch, c), o_rom_addr, (rs + c - 1) & 15);
         if (c >= 1 + lat && c <= n + lat) begin
            check($sformatf("ch%0d wea c%0d", ch, c), o_wea, 1);
            check($sformatf("ch%0d ram_addr c%0d", ch, c), o_ram_addr, (ws + c - 1 - lat) & 15);
            check($sformatf("ch%0d ram_data c%0d", ch, c), o_ram_data, 16 + ((rs + c - 1 - lat) & 15));
         end else begin
            check($sformatf("ch%0d wea_idle c%0d", ch, c), o_wea, 0);
         end
         check($sformatf("ch%0d done c%0d", ch, c), o_done, (c == done_c) ? (1 << ch) : 0);
         check($sformatf("ch%0d busy c%0d", ch, c), o_busy[ch], (c == done_c) ? 0 : 1);
      end
   endtask

   initial begin
      reset = 1'b1; start_dma = '0; start3 = '0;
      data_amt = '0; starting_rom = '0; starting_ram = '0;
      repeat (2) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst wea", ram_wea, 0);
      check("rst rom_addr", rom_addr, 0);
      check("rst ram_addr", ram_addr, 0);
      check("rst busy3", busy3, 0);
      reset = 1'b0;

      // Single block: 4 words, ROM 2.. -> RAM 8..
      set_ch(0, 4, 2, 8); start_dma = 2'b01;
      @(negedge clk); start_dma = '0;
      check("single busy", busy, 2'b01);
      expect_block(0, 4, 2, 8, 1);
      @(negedge clk);
      check("single after busy", busy, 0);
      check("single after done", done, 0);

      // Arbitration from a fresh pointer: ch0 then ch1, twice.
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      set_ch(0, 3, 0, 0); set_ch(1, 2, 5, 4); start_dma = 2'b11;
      @(negedge clk); start_dma = '0;
      check("arb1 busy", busy, 2'b11);
      expect_block(0, 3, 0, 0, 1);
      @(negedge clk);
      check("arb1 gap wea", ram_wea, 0);
      expect_block(1, 2, 5, 4, 1);
      @(negedge clk);
      set_ch(0, 1, 7, 3); set_ch(1, 2, 9, 12); start_dma = 2'b11;
      @(negedge clk); start_dma = '0;
      check("arb2 busy", busy, 2'b11);
      expect_block(0, 1, 7, 3, 1);
      @(negedge clk);
      check("arb2 gap wea", ram_wea, 0);
      expect_block(1, 2, 9, 12, 1);

      // Wrap and latency on the ROM_LATENCY=3 instance.
      use3 = 1'b1;
      set_ch(0, 4, 14, 15); start3 = 2'b01;
      @(negedge clk); start3 = '0;
      check("wrap busy3", busy3, 2'b01);
      expect_block(0, 4, 14, 15, 3);
      use3 = 1'b0;

      // Zero length, then a restart held during a busy block with different fields.
      set_ch(0, 0, 5, 5); start_dma = 2'b01;
      @(negedge clk); start_dma = '0;
      expect_block(0, 0, 5, 5, 1);
      @(negedge clk);
      check("zero after busy", busy, 0);
      set_ch(1, 2, 3, 6); start_dma = 2'b10;
      @(negedge clk);
      set_ch(1, 5, 0, 0);
      check("ign busy", busy, 2'b10);
      expect_block(1, 2, 3, 6, 1);
      start_dma = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("ign idle busy %0d", i), busy, 0);
         check($sformatf("ign idle wea %0d", i), ram_wea, 0);
      end

      // Reset on the second write of an 8-word block.
      set_ch(0, 8, 4, 0); start_dma = 2'b01;
      @(negedge clk); start_dma = '0;
      @(negedge clk);
      check("rstmid rom_addr", rom_addr, 4);
      @(negedge clk);
      check("rstmid wr1", ram_wea, 1);
      @(negedge clk);
      check("rstmid wr2", ram_wea, 1);
      check("rstmid wr2 addr", ram_addr, 1);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("rstmid wea %0d", i), ram_wea, 0);
         check($sformatf("rstmid busy %0d", i), busy, 0);
         check($sformatf("rstmid done %0d", i), done, 0);
         @(negedge clk);
      end
      set_ch(0, 2, 6, 9); set_ch(1, 1, 11, 13); start_dma = 2'b11;
      @(negedge clk); start_dma = '0;
      expect_block(0, 2, 6, 9, 1);
      @(negedge clk);
      expect_block(1, 1, 11, 13, 1);
      @(negedge clk);

      // Held start with amt=1: one transfer every 5 clocks, never accepted in the done clock.
      set_ch(0, 1, 1, 2); start_dma = 2'b01;
      for (int c = 0; c < 15; c++) begin
         int o;
         @(negedge clk);
         o = c % 5;
         check($sformatf("retrig busy c%0d", c), busy, (o < 3) ? 1 : 0);
         check($sformatf("retrig done c%0d", c), done, (o == 3) ? 1 : 0);
         check($sformatf("retrig wea c%0d", c), ram_wea, (o == 2) ? 1 : 0);
      end
      start_dma = '0;
      @(negedge clk);
      check("retrig stop busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
